sprite_mem_arbiter: RTL and testbench
=====================================

# sprite_mem_arbiter

Arbitrates single-port sprite memory access among NREQ requesters (sprite fetch engines, tile loader, host write path). Each access is captured into internal address/data/write-enable registers, issued to the memory for one cycle, and read data is returned to the winning requester. Sits between the sprite requesters and the synchronous-read sprite RAM.

## Interface
- NREQ, 4, number of requesters (2..8)
- AW, 12, memory address width
- DW, 8, memory data width

- Clock  in  1  system clock, all logic on posedge
- Resetn  in  1  reset, synchronous, active-low
- req  in  NREQ  per-requester access request, level
- we  in  NREQ  per-requester write (1) / read (0)
- addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  flattened write data, requester i at [i*DW +: DW]
- gnt  out  NREQ  one-hot grant, one-cycle pulse
- rvalid  out  NREQ  one-hot read-data-valid, one-cycle pulse
- rdata  out  DW  read data, valid when any rvalid bit high
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DW  memory read data, one cycle after address presented

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if any req high, pick winner, pulse gnt[winner], load capture regs (addr, wdata, we, winner index), go ISSUE; else stay.
- ISSUE: mem_addr/mem_wdata driven from capture regs; mem_we = captured we. Write -> IDLE. Read -> WAIT.
- WAIT: latch mem_rdata into rdata, pulse rvalid[winner], go IDLE.
- Requester holds req, we, addr, wdata stable until it sees gnt; may drop or keep req afterward. A held req is re-arbitrated as a new access.
- Winner selection: round-robin; search starts at index after last winner, wraps at NREQ-1 -> 0. Pointer updates only on grant.
- req bits changing in ISSUE/WAIT are ignored until next IDLE.
- rdata holds last read value between reads; mem_addr/mem_wdata hold last values; mem_we low outside ISSUE.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, state=IDLE, last-winner=NREQ-1 (requester 0 first).
- req sampled high in cycle t (IDLE) -> gnt at t+1, mem_we/mem_addr at t+1 (ISSUE), rvalid/rdata at t+2 (WAIT).
- Write throughput: one per 2 cycles; read: one per 3 cycles.
- Simultaneous reqs: exactly one gnt bit per arbitration; no requester starves (granted within NREQ arbitrations).
- Reset mid-operation (ISSUE or WAIT): next cycle IDLE, mem_we=0, no rvalid; pending access dropped, requester must re-request.

## Configuration
- SPRITE_ARB_RR_EN defined: round-robin selection as above.
- Undefined: fixed priority, lowest-index active req wins; last-winner register not built.

## Structure
- Shared package sprite_mem_pkg: state enum (IDLE, ISSUE, WAIT), default AW/DW constants.
- One sub-module: sprite_arb_pick, combinational winner select (req, last-winner -> one-hot, index); fixed-priority variant selected by macro inside it.

## Test plan
- Reset then single read req[2], addr=0x0A5, mem returns 0x3C -> gnt=0100 at t+1, mem_addr=0x0A5, mem_we=0, rvalid=0100 and rdata=0x3C at t+2.
- Single write req[1], addr=0x010, wdata=0x7E -> gnt=0010 at t+1, mem_we=1 one cycle with addr 0x010, data 0x7E; no rvalid.
- All four req held continuously (RR_EN) -> grant order 0,1,2,3,0,... ; without macro -> requester 0 every arbitration.
- req[3] and req[0] together after last winner 3 -> grant 0 first, then 3.
- Resetn low during WAIT of read -> next cycle IDLE, rvalid stays 0000, rdata=0, mem_we=0.
- Idle with no req for 10 cycles -> gnt, rvalid, mem_we remain 0.

Source files
------------

// File: rtl/sprite_mem_pkg.sv
// Shared types and default widths for the sprite memory arbiter slice.
package sprite_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int AW_DEF   = 12;
  localparam int DW_DEF   = 8;

endpackage

// File: rtl/sprite_mem_arbiter_if.sv
// Requester-side and memory-side bus of the sprite memory arbiter.
interface sprite_mem_arbiter_if
  import sprite_mem_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_we;
  logic [DW-1:0]      mem_rdata;

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/sprite_arb_pick.sv
// Combinational winner select. SPRITE_ARB_RR_EN: round-robin after last_i;
// otherwise fixed priority, lowest index wins.
module sprite_arb_pick
  import sprite_mem_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
`ifdef SPRITE_ARB_RR_EN
  input  logic [IW-1:0]   last_i,
`endif
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IW-1:0]   idx_o
);

  logic found;
  int   cand;

  always_comb begin
    gnt_oh_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
`ifdef SPRITE_ARB_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_i) + k) % NREQ;
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        idx_o           = IW'(cand);
        gnt_oh_o[cand]  = 1'b1;
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      cand = i;
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        idx_o           = IW'(cand);
        gnt_oh_o[cand]  = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Single-port sprite RAM arbiter: capture, one-cycle issue, read return.
// Build option SPRITE_ARB_RR_EN selects round-robin instead of fixed priority.
module sprite_mem_arbiter
  import sprite_mem_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  sprite_mem_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [NREQ-1:0] win_oh_q, win_oh_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;

`ifdef SPRITE_ARB_RR_EN
  logic [IW-1:0]   last_q, last_d;
`endif

  sprite_arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i    (bus.req),
`ifdef SPRITE_ARB_RR_EN
    .last_i   (last_q),
`endif
    .gnt_oh_o (pick_oh),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    win_oh_d = win_oh_q;
    rdata_d  = rdata_q;
`ifdef SPRITE_ARB_RR_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = ISSUE;
          addr_d   = bus.addr[int'(pick_idx)*AW +: AW];
          wdata_d  = bus.wdata[int'(pick_idx)*DW +: DW];
          we_d     = bus.we[pick_idx];
          win_oh_d = pick_oh;
`ifdef SPRITE_ARB_RR_EN
          last_d   = pick_idx;
`endif
        end
      end
      ISSUE:   state_d = we_q ? IDLE : WAIT;
      WAIT: begin
        rdata_d = bus.mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      win_oh_q <= '0;
      rdata_q  <= '0;
`ifdef SPRITE_ARB_RR_EN
      last_q   <= IW'(NREQ-1);
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      win_oh_q <= win_oh_d;
      rdata_q  <= rdata_d;
`ifdef SPRITE_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  // Strobes are suppressed while Resetn is low so an aborted access never pulses.
  assign bus.gnt       = (state_q == ISSUE && Resetn) ? win_oh_q : '0;
  assign bus.rvalid    = (state_q == WAIT  && Resetn) ? win_oh_q : '0;
  assign bus.mem_we    = (state_q == ISSUE) && we_q && Resetn;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.rdata     = (state_q == WAIT && Resetn) ? bus.mem_rdata : rdata_q;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_sprite_mem_arbiter;
  import sprite_mem_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int NCYC = 400;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  sprite_mem_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  sprite_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  // Synchronous-read RAM with a bench-side preload port
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;

  always @(posedge Clock) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int n_tests;
  int n_fail;

  typedef struct {
    int              r;
    logic            w;
    logic [AW-1:0]   a;
    logic [DW-1:0]   d;
    logic [NREQ-1:0] exp_gnt;
    logic [DW-1:0]   exp_rd;
  } vec_t;

  vec_t vecs [6];

  // Reference model state
  logic [DW-1:0]   ref_mem [0:63];
  int              order[$];
  int              free_at;
  int              w;
  int              tmp;
  logic            pend [NREQ];
  logic            pwe  [NREQ];
  logic [5:0]      pidx [NREQ];
  logic [DW-1:0]   pdat [NREQ];
  logic [NREQ-1:0] e_gnt [NCYC+4];
  logic [NREQ-1:0] e_rv  [NCYC+4];
  logic            e_we  [NCYC+4];
  logic            e_aset[NCYC+4];
  logic [AW-1:0]   e_addr[NCYC+4];
  logic [DW-1:0]   e_wd  [NCYC+4];
  logic [DW-1:0]   e_rd  [NCYC+4];
  logic [AW-1:0]   cur_addr;
  logic [DW-1:0]   cur_wd;
  logic [DW-1:0]   cur_rd;
  logic [DW-1:0]   last_rd;
  logic            any_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req[r]            = 1'b1;
    bus.we[r]             = wr;
    bus.addr[r*AW +: AW]  = a;
    bus.wdata[r*DW +: DW] = d;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en   = 1'b0;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    clear_inputs();
    tick();
    tick();
    Resetn = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    Resetn  = 1'b0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    clear_inputs();

    vecs[0] = '{2, 1'b0, 12'h0A5, 8'h00, 4'b0100, 8'h3C};
    vecs[1] = '{1, 1'b1, 12'h010, 8'h7E, 4'b0010, 8'h00};
    vecs[2] = '{0, 1'b0, 12'h010, 8'h00, 4'b0001, 8'h7E};
    vecs[3] = '{3, 1'b1, 12'hFFF, 8'hA5, 4'b1000, 8'h00};
    vecs[4] = '{3, 1'b0, 12'hFFF, 8'h00, 4'b1000, 8'hA5};
    vecs[5] = '{1, 1'b0, 12'h000, 8'h00, 4'b0010, 8'h5A};

    load(12'h0A5, 8'h3C);
    load(12'h000, 8'h5A);
    for (int a = 0; a < 64; a++) begin
      ref_mem[a] = 8'(a*37 + 11);
      load(12'(12'h100 + a), ref_mem[a]);
    end

    do_reset();
    check("rst_gnt",       32'(bus.gnt),       32'h0);
    check("rst_rvalid",    32'(bus.rvalid),    32'h0);
    check("rst_rdata",     32'(bus.rdata),     32'h0);
    check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
    check("rst_mem_we",    32'(bus.mem_we),    32'h0);

    // Single-requester transactions from the table
    last_rd = '0;
    for (int i = 0; i < 6; i++) begin
      set_req(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d);
      tick();
      check("vec_gnt",      32'(bus.gnt),      32'(vecs[i].exp_gnt));
      check("vec_mem_addr", 32'(bus.mem_addr), 32'(vecs[i].a));
      check("vec_mem_we",   32'(bus.mem_we),   32'(vecs[i].w));
      check("vec_rv_issue", 32'(bus.rvalid),   32'h0);
      if (vecs[i].w) check("vec_mem_wdata", 32'(bus.mem_wdata), 32'(vecs[i].d));
      clear_inputs();
      tick();
      if (!vecs[i].w) begin
        check("vec_rvalid",  32'(bus.rvalid), 32'(vecs[i].exp_gnt));
        check("vec_rdata",   32'(bus.rdata),  32'(vecs[i].exp_rd));
        check("vec_we_wait", 32'(bus.mem_we), 32'h0);
        last_rd = vecs[i].exp_rd;
        tick();
        check("vec_rdata_hold", 32'(bus.rdata), 32'(last_rd));
      end else begin
        check("vec_wr_no_rv",   32'({bus.rvalid, bus.gnt, bus.mem_we}), 32'h0);
        check("vec_rdata_keep", 32'(bus.rdata), 32'(last_rd));
      end
    end

    // Quiet bus
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_quiet", 32'({bus.gnt, bus.rvalid, bus.mem_we}), 32'h0);
    end

    // Reset asserted while a read is in WAIT
    set_req(1, 1'b0, 12'h0A5, 8'h00);
    tick();
    check("rstw_gnt", 32'(bus.gnt), 32'h2);
    clear_inputs();
    tick();
    Resetn = 1'b0;
    #1;
    check("rstw_rv_during", 32'(bus.rvalid), 32'h0);
    tick();
    Resetn = 1'b1;
    check("rstw_rvalid", 32'(bus.rvalid), 32'h0);
    check("rstw_rdata",  32'(bus.rdata),  32'h0);
    check("rstw_mem_we", 32'(bus.mem_we), 32'h0);
    tick();
    check("rstw_after", 32'({bus.gnt, bus.rvalid, bus.mem_we}), 32'h0);

    // All requesters held: rotation (RR) or requester 0 always (fixed)
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 12'(i*16 + 1), 8'(i));
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef SPRITE_ARB_RR_EN
      w = k % NREQ;
`else
      w = 0;
`endif
      check("held_gnt",  32'(bus.gnt),      32'(1 << w));
      check("held_addr", 32'(bus.mem_addr), 32'(w*16 + 1));
      tick();
      check("held_gap",  32'(bus.gnt),      32'h0);
    end
    clear_inputs();
    tick();

    // Requesters 3 and 0 together right after requester 3 won
    set_req(3, 1'b1, 12'h020, 8'h11);
    tick();
    check("r30_pre", 32'(bus.gnt), 32'h8);
    clear_inputs();
    tick();
    set_req(0, 1'b1, 12'h030, 8'h22);
    set_req(3, 1'b1, 12'h031, 8'h33);
    tick();
    check("r30_first", 32'(bus.gnt), 32'h1);
    bus.req[0] = 1'b0;
    tick();
    tick();
    check("r30_second", 32'(bus.gnt), 32'h8);
    clear_inputs();
    tick();

    // Randomized traffic against the transaction-level model
    do_reset();
    order = {};
    for (int i = 0; i < NREQ; i++) begin
      order.push_back(i);
      pend[i] = 1'b0;
      pwe[i]  = 1'b0;
      pidx[i] = '0;
      pdat[i] = '0;
    end
    for (int c = 0; c < NCYC + 4; c++) begin
      e_gnt[c] = '0; e_rv[c] = '0; e_we[c] = 1'b0; e_aset[c] = 1'b0;
      e_addr[c] = '0; e_wd[c] = '0; e_rd[c] = '0;
    end
    free_at  = 0;
    cur_addr = '0;
    cur_wd   = '0;
    cur_rd   = '0;
    for (int c = 0; c < NCYC; c++) begin
      if (e_aset[c]) begin
        cur_addr = e_addr[c];
        cur_wd   = e_wd[c];
      end
      if (e_rv[c] != '0) cur_rd = e_rd[c];
      check("rnd_gnt",       32'(bus.gnt),       32'(e_gnt[c]));
      check("rnd_rvalid",    32'(bus.rvalid),    32'(e_rv[c]));
      check("rnd_mem_we",    32'(bus.mem_we),    32'(e_we[c]));
      check("rnd_mem_addr",  32'(bus.mem_addr),  32'(cur_addr));
      check("rnd_mem_wdata", 32'(bus.mem_wdata), 32'(cur_wd));
      check("rnd_rdata",     32'(bus.rdata),     32'(cur_rd));

      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 35) begin
          pend[i] = 1'b1;
          pwe[i]  = 1'($urandom_range(0, 1));
          pidx[i] = 6'($urandom_range(0, 63));
          pdat[i] = 8'($urandom);
        end
        bus.req[i]            = pend[i];
        bus.we[i]             = pwe[i];
        bus.addr[i*AW +: AW]  = 12'(12'h100 + pidx[i]);
        bus.wdata[i*DW +: DW] = pdat[i];
      end

      any_pend = 1'b0;
      for (int i = 0; i < NREQ; i++) any_pend = any_pend | pend[i];
      if (c >= free_at && any_pend) begin
        w = -1;
`ifdef SPRITE_ARB_RR_EN
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && pend[order[k]]) w = order[k];
        while (order[$] != w) begin
          tmp = order.pop_front();
          order.push_back(tmp);
        end
`else
        for (int i = 0; i < NREQ; i++)
          if (w < 0 && pend[i]) w = i;
`endif
        e_gnt[c+1]  = NREQ'(1 << w);
        e_we[c+1]   = pwe[w];
        e_aset[c+1] = 1'b1;
        e_addr[c+1] = 12'(12'h100 + pidx[w]);
        e_wd[c+1]   = pdat[w];
        if (pwe[w]) begin
          ref_mem[pidx[w]] = pdat[w];
          free_at = c + 2;
        end else begin
          e_rv[c+2] = NREQ'(1 << w);
          e_rd[c+2] = ref_mem[pidx[w]];
          free_at = c + 3;
        end
        pend[w] = 1'b0;
      end
      tick();
    end
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
